// File: rtl/dm_block_mover.sv
// rtl/dm_block_mover.sv - fill/copy sequencer that owns the single-port dm while busy
module dm_block_mover #(
   parameter int DW = 30,
   parameter int AW = 10,
   parameter int LW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          op,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [LW-1:0] len,
   input  logic [DW-1:0] pattern,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [LW-1:0] words_done,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_datain,
   output logic          dm_memwr,
   input  logic [DW-1:0] dm_dataout
);

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   localparam logic [LW-1:0] MAXLEN = {1'b1, {AW{1'b0}}};

   state_t        state;
   logic          op_r;
   logic          desc_r;
   logic [AW-1:0] src_r;
   logic [AW-1:0] dst_r;
   logic [LW-1:0] len_r;
   logic [AW-1:0] ofs;

   logic [LW-1:0] lenc;
   logic [LW-1:0] lenm1;
   logic          desc_in;
   logic [AW-1:0] ofs_first;
   logic [AW-1:0] ofs_next;
   logic          last;

   assign lenc      = (len > MAXLEN) ? MAXLEN : len;
   assign lenm1     = lenc - LW'(1);
   // Overlapping copies toward higher addresses must run top-down to avoid clobbering the source.
   assign desc_in   = op && (dst > src);
   assign ofs_first = desc_in ? lenm1[AW-1:0] : '0;
   assign ofs_next  = desc_r ? ofs - AW'(1) : ofs + AW'(1);
   assign last      = (words_done + LW'(1)) == len_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_r       <= 1'b0;
         desc_r     <= 1'b0;
         src_r      <= '0;
         dst_r      <= '0;
         len_r      <= '0;
         ofs        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         words_done <= '0;
         dm_addr    <= '0;
         dm_datain  <= '0;
         dm_memwr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r       <= op;
                  desc_r     <= desc_in;
                  src_r      <= src;
                  dst_r      <= dst;
                  len_r      <= lenc;
                  ofs        <= ofs_first;
                  words_done <= '0;
                  if (lenc == '0) begin
                     state   <= FIN;
                     done    <= 1'b1;
                     aborted <= 1'b0;
                  end else if (op) begin
                     state   <= RD;
                     busy    <= 1'b1;
                     dm_addr <= src + ofs_first;
                  end else begin
                     state     <= WR;
                     busy      <= 1'b1;
                     dm_addr   <= dst + ofs_first;
                     dm_datain <= pattern;
                     dm_memwr  <= 1'b1;
                  end
               end
            end
            RD: begin
               if (abort) begin
                  state   <= FIN;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else begin
                  // dm_datain doubles as the holding register for the word just read.
                  state     <= WR;
                  dm_addr   <= dst_r + ofs;
                  dm_datain <= dm_dataout;
                  dm_memwr  <= 1'b1;
               end
            end
            WR: begin
               words_done <= words_done + LW'(1);
               if (last || abort) begin
                  state    <= FIN;
                  busy     <= 1'b0;
                  dm_memwr <= 1'b0;
                  done     <= 1'b1;
                  aborted  <= abort;
               end else begin
                  ofs <= ofs_next;
                  if (op_r) begin
                     state    <= RD;
                     dm_memwr <= 1'b0;
                     dm_addr  <= src_r + ofs_next;
                  end else begin
                     dm_addr  <= dst_r + ofs_next;
                  end
               end
            end
            FIN: begin
               state   <= IDLE;
               done    <= 1'b0;
               aborted <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_block_mover.sv
// tb/tb_dm_block_mover.sv - randomized bench for dm_block_mover against a per-word memory model
module tb_dm_block_mover;

   localparam int DW = 30;
   localparam int AW = 10;
   localparam int LW = 11;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [LW-1:0] len;
   logic [DW-1:0] pattern;
   logic          abort;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [LW-1:0] words_done;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_datain;
   logic          dm_memwr;
   logic [DW-1:0] dm_dataout;

   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] refm [DEPTH];
   logic [AW-1:0] wq[$];

   int total = 0;
   int bad = 0;

   dm_block_mover #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
      .len(len), .pattern(pattern), .abort(abort), .busy(busy), .done(done),
      .aborted(aborted), .words_done(words_done), .dm_addr(dm_addr),
      .dm_datain(dm_datain), .dm_memwr(dm_memwr), .dm_dataout(dm_dataout)
   );

   always #5 clk = ~clk;

   assign dm_dataout = mem[dm_addr];

   always @(posedge clk) begin
      if (dm_memwr) begin
         mem[dm_addr] <= dm_datain;
         wq.push_back(dm_addr);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mem_chk(input string tag);
      int diffs = 0;
      for (int i = 0; i < DEPTH; i++)
         if (mem[i] !== refm[i]) diffs++;
      chk(tag, diffs, 0);
   endtask

   task automatic poke(input int a, input logic [DW-1:0] v);
      mem[a]  = v;
      refm[a] = v;
   endtask

   // abort_at: abort during the abort_at-th write cycle (0 = never); bump: pulse start while busy
   task automatic run_cmd(input string tag, input logic o, input int s, input int d, input int l,
                          input logic [DW-1:0] p, input int abort_at, input bit bump);
      int n, neff, exp_cyc, wrs, cyc;
      bit desc, got_done;
      logic [AW-1:0] ea[$];
      logic [AW-1:0] a, b;
      int i;
      n    = (l > DEPTH) ? DEPTH : l;
      neff = (abort_at > 0 && abort_at < n) ? abort_at : n;
      desc = o && (d > s);
      for (int k = 0; k < neff; k++) begin
         i = desc ? n - 1 - k : k;
         a = AW'(d + i);
         b = AW'(s + i);
         refm[a] = o ? refm[b] : p;
         ea.push_back(a);
      end
      exp_cyc = 1 + (o ? 2 * neff : neff);

      @(negedge clk);
      wq.delete();
      start = 1'b1; op = o; src = AW'(s); dst = AW'(d); len = LW'(l); pattern = p;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; wrs = 0; got_done = 0;
      while (cyc < 2 * DEPTH + 20) begin
         abort = 1'b0;
         if (bump && cyc == 2) begin
            start = 1'b1; op = 1'b1; len = LW'(1); dst = AW'(d + 100);
         end else begin
            start = 1'b0;
         end
         if (dm_memwr) begin
            wrs++;
            if (abort_at > 0 && wrs == abort_at) abort = 1'b1;
         end
         if (done) begin
            got_done = 1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0;
      start = 1'b0;
      chk({tag, " timeout"}, !got_done, 0);
      chk({tag, " done_cycle"}, cyc, exp_cyc);
      chk({tag, " aborted"}, aborted, (abort_at > 0 && abort_at < n));
      chk({tag, " busy_at_done"}, busy, 0);
      chk({tag, " wr_at_done"}, dm_memwr, 0);
      chk({tag, " words_done"}, words_done, neff);
      begin
         int addr_bad = (wq.size() != ea.size()) ? 1 : 0;
         if (addr_bad == 0)
            foreach (ea[j]) if (wq[j] !== ea[j]) addr_bad++;
         chk({tag, " wr_addr_seq"}, addr_bad, 0);
         chk({tag, " wr_count"}, wq.size(), neff);
      end
      mem_chk({tag, " mem"});
      @(negedge clk);
      chk({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0;
      pattern = '0; abort = 1'b0;
      for (int i = 0; i < DEPTH; i++) poke(i, DW'($urandom));
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst aborted", aborted, 0);
      chk("rst words_done", words_done, 0);
      chk("rst dm_addr", dm_addr, 0);
      chk("rst dm_datain", dm_datain, 0);
      chk("rst dm_memwr", dm_memwr, 0);
      rst = 1'b0;

      run_cmd("fill_wrap", 1'b0, 0, 'h3FE, 4, 30'h3FFFFFFF, 0, 0);
      for (int i = 0; i < 4; i++) poke('h100 + i, DW'(i + 1));
      run_cmd("copy", 1'b1, 'h100, 'h200, 4, '0, 0, 0);
      for (int i = 0; i < 4; i++) poke('h10 + i, DW'(i + 1));
      run_cmd("copy_overlap", 1'b1, 'h10, 'h12, 4, '0, 0, 0);
      run_cmd("len0", 1'b0, 0, 'h50, 0, 30'h123, 0, 0);
      run_cmd("fill_abort", 1'b0, 0, 'h80, 10, 30'h2AAAAAAA, 4, 1);
      run_cmd("copy_abort", 1'b1, 'h180, 'h1A0, 6, '0, 3, 0);
      run_cmd("fill_clamp", 1'b0, 0, 5, 1100, 30'h155, 0, 0);

      for (int t = 0; t < 8; t++)
         run_cmd($sformatf("rand%0d", t), 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)),
                 DW'($urandom), 0, 0);

      // reset in the middle of an ascending copy after two words have landed
      @(negedge clk);
      wq.delete();
      start = 1'b1; op = 1'b1; src = AW'('h340); dst = AW'('h300); len = LW'(8);
      @(negedge clk);
      start = 1'b0;
      begin
         int guard = 0;
         while (words_done != LW'(2) && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         chk("rst_mid timeout", guard < 100, 1);
      end
      for (int i = 0; i < 2; i++) refm['h300 + i] = refm['h340 + i];
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid busy", busy, 0);
      chk("rst_mid dm_memwr", dm_memwr, 0);
      chk("rst_mid words_done", words_done, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid wr_count", wq.size(), 2);
      mem_chk("rst_mid mem");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
